// File: rtl/jtag_scan_sequencer.sv
// jtag_scan_sequencer
//   On-chip JTAG master running from the system clock. Accepts scan commands
//   (TAP reset, shift IR, shift DR, idle TCKs) over a valid/ready port, drives
//   tck/tms/tdi to the TAP and returns the tdo bits captured during the shift.
//
// Ports
//   clk, rst_n           system clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready only when idle
//   cmd_type             00 TAP reset, 01 shift IR, 10 shift DR, 11 idle TCKs
//   cmd_len              shift length / idle TCK count
//   cmd_data             bits to shift, LSB first
//   rsp_valid            one-clk completion pulse (no back-pressure)
//   rsp_data, rsp_err    captured tdo bits / illegal-length flag, held
//   tck, tms, tdi        registered JTAG outputs
//   tdo                  JTAG input, already synchronous to clk
module jtag_scan_sequencer #(
  parameter  int unsigned DATA_W  = 32,
  parameter  int unsigned TCK_DIV = 2,
  localparam int unsigned LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);

  localparam int unsigned PH_W  = $clog2(2 * TCK_DIV);
  localparam int unsigned CNT_W = LEN_W + 3;
  localparam int unsigned IDX_W = $clog2(DATA_W);

  localparam logic [PH_W-1:0] PH_LAST     = PH_W'(2 * TCK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HIGH     = PH_W'(TCK_DIV);
  localparam logic [PH_W-1:0] PH_PRE_RISE = PH_W'(TCK_DIV - 1);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    CMD_TAP_RESET = 2'b00,
    CMD_SHIFT_IR  = 2'b01,
    CMD_SHIFT_DR  = 2'b10,
    CMD_IDLE      = 2'b11
  } cmd_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_e              type_q, type_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              err_q, err_d;
  logic              boot_q, boot_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;

  logic              tck_done;
  logic              tck_rise;
  logic              finish;
  logic              is_scan_cmd;
  logic              scan_q;
  logic              active_d;
  logic [CNT_W-1:0]  pre_last;
  logic [CNT_W-1:0]  len_last_q;
  logic [CNT_W-1:0]  len_last_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    len_d      = len_q;
    data_d     = data_q;
    cap_d      = cap_q;
    err_d      = err_q;
    boot_d     = boot_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    finish     = 1'b0;

    tck_done    = (phase_q == PH_LAST);
    tck_rise    = (phase_q == PH_PRE_RISE);
    is_scan_cmd = cmd_type[0] ^ cmd_type[1];
    scan_q      = (type_q == CMD_SHIFT_IR) || (type_q == CMD_SHIFT_DR);
    len_last_q  = CNT_W'(len_q) - CNT_W'(1);

    unique case (type_q)
      CMD_TAP_RESET: pre_last = CNT_W'(5);
      CMD_SHIFT_IR:  pre_last = CNT_W'(3);
      CMD_SHIFT_DR:  pre_last = CNT_W'(2);
      default:       pre_last = '0;
    endcase

    unique case (state_q)
      // BOOT reuses the TAP-reset preamble; boot_q suppresses its response.
      S_BOOT: begin
        state_d = S_PRE;
        type_d  = CMD_TAP_RESET;
        cnt_d   = '0;
        phase_d = '0;
        err_d   = 1'b0;
        boot_d  = 1'b1;
      end

      S_IDLE, S_RESP: begin
        if (state_q == S_RESP) state_d = S_IDLE;
        if (cmd_valid) begin
          type_d  = cmd_e'(cmd_type);
          len_d   = cmd_len;
          data_d  = cmd_data;
          cap_d   = '0;
          cnt_d   = '0;
          phase_d = '0;
          err_d   = is_scan_cmd && ((cmd_len == '0) || (cmd_len > LEN_W'(DATA_W)));
          // Illegal lengths park one clk in PRE (no tck activity) before RESP.
          if (err_d) begin
            state_d = S_PRE;
          end else if (cmd_e'(cmd_type) == CMD_IDLE) begin
            if (cmd_len == '0) begin
              state_d = S_RESP;
              finish  = 1'b1;
            end else begin
              state_d = S_SHIFT;
            end
          end else begin
            state_d = S_PRE;
          end
        end
      end

      S_PRE: begin
        if (err_q) begin
          state_d = S_RESP;
          finish  = 1'b1;
        end else begin
          phase_d = tck_done ? '0 : phase_q + PH_W'(1);
          if (tck_done) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == pre_last) begin
              cnt_d = '0;
              if (type_q == CMD_TAP_RESET) begin
                if (boot_q) begin
                  state_d = S_IDLE;
                  boot_d  = 1'b0;
                end else begin
                  state_d = S_RESP;
                  finish  = 1'b1;
                end
              end else begin
                state_d = S_SHIFT;
              end
            end
          end
        end
      end

      S_SHIFT: begin
        phase_d = tck_done ? '0 : phase_q + PH_W'(1);
        if (tck_rise && scan_q) cap_d[cnt_q[IDX_W-1:0]] = tdo;
        if (tck_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_last_q) begin
            cnt_d = '0;
            if (type_q == CMD_IDLE) begin
              state_d = S_RESP;
              finish  = 1'b1;
            end else begin
              state_d = S_POST;
            end
          end
        end
      end

      S_POST: begin
        phase_d = tck_done ? '0 : phase_q + PH_W'(1);
        if (tck_done) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = S_RESP;
            finish  = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      rsp_err_d  = err_d;
      rsp_data_d = err_d ? '0 : cap_d;
    end

    // JTAG pins are registered from the next-state view so tms/tdi change on
    // the same edge that opens each tck low phase.
    len_last_d = CNT_W'(len_d) - CNT_W'(1);
    active_d   = !err_d && ((state_d == S_PRE) || (state_d == S_SHIFT) || (state_d == S_POST));
    tck_d      = 1'b0;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    if (active_d) begin
      tck_d = (phase_d >= PH_HIGH);
      tms_d = 1'b0;
      tdi_d = 1'b0;
      case (state_d)
        S_PRE: begin
          case (type_d)
            CMD_TAP_RESET: tms_d = (cnt_d < CNT_W'(5));
            CMD_SHIFT_IR:  tms_d = (cnt_d < CNT_W'(2));
            CMD_SHIFT_DR:  tms_d = (cnt_d == '0);
            default:       tms_d = 1'b0;
          endcase
        end
        S_SHIFT: begin
          tdi_d = data_d[cnt_d[IDX_W-1:0]];
          tms_d = (type_d != CMD_IDLE) && (cnt_d == len_last_d);
        end
        S_POST:  tms_d = (cnt_d == '0);
        default: tms_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      phase_q    <= '0;
      cnt_q      <= '0;
      type_q     <= CMD_TAP_RESET;
      len_q      <= '0;
      data_q     <= '0;
      cap_q      <= '0;
      err_q      <= 1'b0;
      boot_q     <= 1'b1;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cap_q      <= cap_d;
      err_q      <= err_d;
      boot_q     <= boot_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      tck_q      <= tck_d;
      tms_q      <= tms_d;
      tdi_q      <= tdi_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign tck       = tck_q;
  assign tms       = tms_q;
  assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// tb_jtag_scan_sequencer
//   Drives scan commands into jtag_scan_sequencer with a 1-bit bypass TAP on
//   the JTAG pins. Expected responses, TMS/TDI sequences and latencies are
//   queued at issue time and compared when rsp_valid fires.
module tb_jtag_scan_sequencer;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TCK_DIV = 2;
  localparam int unsigned LEN_W   = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_type = 2'b00;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              tck, tms, tdi;
  logic              tdo = 1'b0;

  always #5 clk = ~clk;

  jtag_scan_sequencer #(.DATA_W(DATA_W), .TCK_DIV(TCK_DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  // bypass TAP
  always @(posedge tck) tdo <= tdi;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              err;
    int unsigned       n;
    logic [63:0]       tms;
    logic [63:0]       tdi;
    int unsigned       lat;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] t, input int unsigned l, input logic [DATA_W-1:0] d);
    exp_t        e;
    int unsigned k;
    logic [63:0] dd;
    e.data = '0; e.err = 1'b0; e.n = 0; e.tms = '0; e.tdi = '0; e.lat = 0;
    if ((t == 2'b01 || t == 2'b10) && (l == 0 || l > DATA_W)) begin
      e.err = 1'b1;
      e.lat = 2;
      return e;
    end
    k = 0;
    if (t == 2'b00) begin
      for (int i = 0; i < 6; i++) begin e.tms[k] = (i < 5); k++; end
    end else begin
      if (t == 2'b01) begin
        e.tms[0] = 1'b1; e.tms[1] = 1'b1; k = 4;
      end else if (t == 2'b10) begin
        e.tms[0] = 1'b1; k = 3;
      end
      for (int i = 0; i < int'(l); i++) begin
        e.tms[k] = (t != 2'b11) && (i == int'(l) - 1);
        e.tdi[k] = d[i];
        k++;
      end
      if (t != 2'b11) begin
        e.tms[k] = 1'b1; k++;
        e.tms[k] = 1'b0; k++;
      end
    end
    e.n = k;
    e.lat = (k == 0) ? 1 : 1 + 2 * TCK_DIV * k;
    if (t == 2'b01 || t == 2'b10) begin
      dd = {32'b0, d} << 1;
      dd = dd & ((64'd1 << l) - 64'd1);
      e.data = dd[DATA_W-1:0];
    end
    return e;
  endfunction

  // monitor
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int unsigned obs_n = 0;
  logic [63:0] obs_tms = '0, obs_tdi = '0;
  int unsigned first_rise_cyc = 0, acc_cyc = 0, last_rsp_cyc = 0, acc_gap = 0, n_acc = 0;
  logic        prev_tck = 1'b0, prev_rsp = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      obs_n = 0; obs_tms = '0; obs_tdi = '0;
      sb.delete();
      prev_tck = 1'b0; prev_rsp = 1'b0;
    end else begin
      if (tck && !prev_tck) begin
        if (obs_n == 0) first_rise_cyc = cyc;
        if (obs_n < 64) begin obs_tms[obs_n] = tms; obs_tdi[obs_n] = tdi; end
        obs_n++;
      end
      if (rsp_valid) begin
        check("rsp_pulse", {63'b0, prev_rsp}, 64'd0);
        check("rsp_expected", {63'b0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_data", {32'b0, rsp_data}, {32'b0, e.data});
          check("rsp_err", {63'b0, rsp_err}, {63'b0, e.err});
          check("tck_count", 64'(obs_n), 64'(e.n));
          check("tms_seq", obs_tms, e.tms);
          check("tdi_seq", obs_tdi, e.tdi);
          check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        end
        last_rsp_cyc = cyc;
        obs_n = 0; obs_tms = '0; obs_tdi = '0;
      end
      if (cmd_valid && cmd_ready) begin
        n_acc++;
        acc_gap = cyc - last_rsp_cyc;
        acc_cyc = cyc;
        obs_n = 0; obs_tms = '0; obs_tdi = '0;
      end
      prev_tck = tck;
      prev_rsp = rsp_valid;
    end
  end

  // stimulus
  int unsigned ready_cyc = 0;

  task automatic send(input logic [1:0] t, input int unsigned l, input logic [DATA_W-1:0] d);
    int unsigned n;
    sb.push_back(model(t, l, d));
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = l[LEN_W-1:0];
    cmd_data  = d;
    n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    check("accept_in_time", {63'b0, n < 2000}, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain_in_time", {63'b0, n < 2000}, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    check("ready_in_time", {63'b0, n < 2000}, 64'd1);
    ready_cyc = cyc;
  endtask

  task automatic check_boot();
    check("boot_tck_count", 64'(obs_n), 64'd6);
    check("boot_tms", obs_tms, 64'h1F);
    check("boot_tdi", obs_tdi, 64'h0);
    check("boot_ready_delay", 64'(ready_cyc - first_rise_cyc), 64'(2 * 6 * TCK_DIV - TCK_DIV));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tck"}, {63'b0, tck}, 64'd0);
    check({tag, "_tms"}, {63'b0, tms}, 64'd1);
    check({tag, "_tdi"}, {63'b0, tdi}, 64'd0);
    check({tag, "_cmd_ready"}, {63'b0, cmd_ready}, 64'd0);
    check({tag, "_rsp_valid"}, {63'b0, rsp_valid}, 64'd0);
    check({tag, "_rsp_data"}, {32'b0, rsp_data}, 64'd0);
    check({tag, "_rsp_err"}, {63'b0, rsp_err}, 64'd0);
  endtask

  initial begin
    int unsigned n;
    int unsigned acc0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_ready();
    check_boot();
    check("boot_no_accept", 64'(n_acc), 64'd0);

    send(2'b10, 8, 32'hA5);         drain();
    send(2'b01, 4, 32'h2);          drain();
    send(2'b10, 0, 32'hFF);         drain();
    repeat (5) @(negedge clk);
    check("err_hold", {63'b0, rsp_err}, 64'd1);
    send(2'b10, 33, 32'hFF);        drain();
    send(2'b11, 3, 32'h0);          drain();
    check("err_cleared", {63'b0, rsp_err}, 64'd0);
    send(2'b11, 0, 32'h0);          drain();
    send(2'b10, 32, 32'hDEADBEEF);  drain();
    repeat (5) @(negedge clk);
    check("data_hold", {32'b0, rsp_data}, 64'hBD5B7DDE);
    send(2'b01, 1, 32'h1);          drain();
    send(2'b00, 0, 32'h0);          drain();

    // reset in the middle of a DR shift (bit 5)
    send(2'b10, 8, 32'hA5);
    n = 0;
    while (obs_n < 9 && n < 2000) begin @(negedge clk); n++; end
    check("reach_bit5", {63'b0, n < 2000}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_ready();
    check_boot();
    send(2'b10, 8, 32'hA5);         drain();

    // command held while busy, then back-to-back accept in the RESP cycle
    acc0 = n_acc;
    send(2'b11, 2, 32'h0);
    send(2'b10, 8, 32'h3C);
    check("b2b_gap", 64'(acc_gap), 64'd0);
    drain();
    check("accept_count", 64'(n_acc - acc0), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
